// File: rtl/word_ser_pkg.sv
// Shared types and defaults for the MSB-first word serializer.
package word_ser_pkg;

  localparam int WORD_SER_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/word_ser_hold.sv
// One-word skid buffer that queues the next word while the shifter is busy.
module word_ser_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         drain,
  output logic         full,
  output logic [W-1:0] data
);

  // A load needs an empty buffer and a drain needs a full one, so the two never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial converter, MSB first, with a valid/ready handshake on both sides.
// Define WORD_SER_HOLD_EN to add a one-word hold buffer for back-to-back streaming.
//
// state | meaning
// IDLE  | shift register empty, nothing on dout
// SHIFT | word loaded, dout carries its current MSB
module word_serializer
  import word_ser_pkg::*;
#(
  parameter int W = WORD_SER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         dout_first,
  output logic         dout_last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   sreg_q;
  logic [CW-1:0]  cnt_q;
  logic           accept;
  logic           consume;
  logic           last_bit;
  logic           next_avail;
  logic [W-1:0]   next_data;

  assign accept   = din_valid && din_ready;
  assign consume  = (state_q == SHIFT) && dout_ready;
  assign last_bit = (cnt_q == CW'(W - 1));

`ifdef WORD_SER_HOLD_EN
  logic         hold_full;
  logic [W-1:0] hold_data;
  logic         hold_load;
  logic         hold_drain;

  // Ready comes from the registered hold flag only, so a word offered while
  // the hold drains waits one cycle.
  assign din_ready  = !hold_full;
  assign hold_load  = accept && (state_q == SHIFT) && !(consume && last_bit);
  assign hold_drain = consume && last_bit && hold_full;
  assign next_avail = hold_full || accept;
  assign next_data  = hold_full ? hold_data : din;

  word_ser_hold #(.W(W)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (hold_load),
    .load_data (din),
    .drain     (hold_drain),
    .full      (hold_full),
    .data      (hold_data)
  );
`else
  assign din_ready  = (state_q == IDLE);
  assign next_avail = accept;
  assign next_data  = din;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (consume && last_bit && !next_avail) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_valid = (state_q == SHIFT);
    dout       = dout_valid && sreg_q[W-1];
    dout_first = dout_valid && (cnt_q == '0);
    dout_last  = dout_valid && last_bit;
  end

  // Consuming the last bit clears the register when no word follows, keeping dout low in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        sreg_q <= din;
        cnt_q  <= '0;
      end
    end else if (consume) begin
      if (last_bit) begin
        sreg_q <= next_avail ? next_data : '0;
        cnt_q  <= '0;
      end else begin
        sreg_q <= {sreg_q[W-2:0], 1'b0};
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: accepted words expand into expected bit records.
module tb_word_serializer;
  import word_ser_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic         dout;
  logic         dout_valid;
  logic         dout_ready = 1'b1;
  logic         dout_first;
  logic         dout_last;

  word_serializer #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_first (dout_first),
    .dout_last  (dout_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   prev_stall = 0;
  logic [2:0] prev_out = '0;
  bit   awaiting = 0;
  int   gap_cnt = 0;
  int   last_gap = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Monitor: pops expected bits when the DUT hands one over, pushes a word's bits when one is accepted.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!dout_valid) check("idle_flags", {dout, dout_first, dout_last}, 0);
        if (prev_stall) begin
          check("stall_valid", dout_valid, 1);
          check("stall_hold", {dout, dout_first, dout_last}, prev_out);
        end
`ifndef WORD_SER_HOLD_EN
        check("ready_idle", din_ready, !dout_valid);
`endif
        if (dout_valid && awaiting) begin
          last_gap = gap_cnt;
          awaiting = 0;
        end else if (!dout_valid && awaiting) begin
          gap_cnt++;
        end
        if (dout_valid && dout_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_bit", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("bit", {dout, dout_first, dout_last}, e);
          end
          if (dout_last) begin
            awaiting = 1;
            gap_cnt = 0;
          end
        end
        if (din_valid && din_ready) begin
          for (int i = 0; i < W; i++) begin
            e.b = din[W-1-i];
            e.f = (i == 0);
            e.l = (i == W - 1);
            sb.push_back(e);
          end
        end
        prev_stall = dout_valid && !dout_ready;
        prev_out = {dout, dout_first, dout_last};
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din_valid = 0;
    dout_ready = 1;
    reset = 1;
    repeat (2) cyc();
    @(negedge clk);
    sb.delete();
    prev_stall = 0;
    awaiting = 0;
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_first_last", {dout_first, dout_last}, 0);
    check("rst_din_ready", din_ready, 1);
    cyc();
    reset = 0;
  endtask

  task automatic send(input logic [W-1:0] w, input bit check_lat);
    int t;
    din = w;
    din_valid = 1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!din_ready && t < 200);
    if (!din_ready) check("send_timeout", 0, 1);
    cyc();
    din_valid = 0;
    if (check_lat) begin
      @(negedge clk);
      check("first_latency", {dout_valid, dout_first, dout}, {2'b11, w[W-1]});
      #4;
    end
  endtask

  task automatic drain();
    int t;
    din_valid = 0;
    dout_ready = 1;
    t = 0;
    while ((sb.size() != 0 || dout_valid) && t < 500) begin
      cyc();
      t++;
    end
    check("drain_left", sb.size(), 0);
    check("drain_valid", dout_valid, 0);
  endtask

  initial begin
    do_reset();

    send(8'h96, 1);
    drain();

    send(8'h03, 1);
    repeat (3) cyc();
    dout_ready = 0;
    repeat (3) cyc();
    dout_ready = 1;
    drain();

    send(8'hFF, 0);
    send(8'h00, 0);
    drain();
`ifdef WORD_SER_HOLD_EN
    check("b2b_gap", last_gap, 0);
`else
    check("b2b_gap", last_gap, 1);
`endif

    send(8'hA5, 1);
    repeat (4) cyc();
    do_reset();
    send(8'h0C, 1);
    drain();

    for (int c = 0; c < 400; c++) begin
      din = W'($urandom);
      din_valid = ($urandom_range(0, 9) < 7);
      dout_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the parallel word width in bits (W >= 2).
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-004 Port din SHALL be an input, W bits: the parallel word to serialize.
REQ-005 Port din_valid SHALL be an input, 1 bit: din holds a word to transfer.
REQ-006 Port din_ready SHALL be an output, 1 bit: the block accepts din this cycle.
REQ-007 Port dout SHALL be an output, 1 bit: the serial bit, MSB first, feeding the serial remainder/divisibility stage.
REQ-008 Port dout_valid SHALL be an output, 1 bit: dout carries a valid bit.
REQ-009 Port dout_ready SHALL be an input, 1 bit: downstream consumes dout this cycle.
REQ-010 Port dout_first SHALL be an output, 1 bit: dout is bit W-1 of a word.
REQ-011 Port dout_last SHALL be an output, 1 bit: dout is bit 0 of a word.

Function
REQ-012 A word SHALL be accepted on a cycle where din_valid && din_ready; a bit SHALL be consumed on a cycle where dout_valid && dout_ready.
REQ-013 The state machine SHALL have two states: IDLE (shift register empty) and SHIFT (word loaded).
REQ-014 From IDLE, an accepted word SHALL load the shift register and move to SHIFT; dout_valid SHALL be 1 the next cycle with dout = din[W-1].
REQ-015 In SHIFT, each consumed bit SHALL shift left by one and increment a bit counter of width clog2(W); dout SHALL always be the register MSB.
REQ-016 dout_first SHALL be 1 when the counter is 0; dout_last SHALL be 1 when the counter is W-1; both SHALL be 0 when dout_valid is 0.
REQ-017 When dout_ready is 0, dout, dout_first, dout_last and the counter SHALL hold unchanged.
REQ-018 On consuming the last bit, the counter SHALL wrap to 0; the block SHALL reload from the next available word (see Configuration) and stay in SHIFT, otherwise go to IDLE with dout_valid = 0 on the next cycle.
REQ-019 din_valid while din_ready is 0 SHALL have no effect; the block SHALL never drop or duplicate a word or bit.
REQ-020 din_ready SHALL be a function of registered state only, with no combinational path from dout_ready or din_valid.

Reset
REQ-021 While reset is 1 at a clock edge, the state SHALL go to IDLE, the counter to 0, and the hold buffer to empty.
REQ-022 Out of reset: dout_valid = 0, dout = 0, dout_first = 0, dout_last = 0, din_ready = 1.
REQ-023 Reset mid-word SHALL discard the partial word and any held word; the first accepted word after reset SHALL start with dout_first = 1.

Configuration
REQ-024 Macro WORD_SER_HOLD_EN, when defined, SHALL add one W-bit hold register: din_ready = !hold_full; a word accepted in SHIFT fills hold; on last-bit consumption a held word SHALL load with no idle cycle (dout_first next cycle); a word arriving in the same cycle the hold drains SHALL NOT be accepted (ready is registered).
REQ-025 Without WORD_SER_HOLD_EN, din_ready SHALL equal (state == IDLE); consecutive words SHALL therefore have at least one cycle with dout_valid = 0 between them.

Structure
REQ-026 Package word_ser_pkg SHALL hold the state enum typedef (IDLE, SHIFT) and the default width constant WORD_SER_W = 8.
REQ-027 The hold register SHALL be sub-module word_ser_hold (valid flag and data, load/drain ports), instantiated only under WORD_SER_HOLD_EN.

Verification
REQ-028 W=8, din=8'h96, dout_ready=1 -> dout = 1,0,0,1,0,1,1,0 on 8 consecutive cycles starting 1 cycle after accept; dout_first on bit 1, dout_last on bit 8.
REQ-029 Word 8'h03 with dout_ready low for 3 cycles at bit 4 -> dout, the flags and the counter frozen for 3 cycles, then the stream resumes with no bit lost (sequence 0,0,0,0,0,0,1,1).
REQ-030 HOLD_EN: words 8'hFF then 8'h00 presented back-to-back -> 16 contiguous valid bits, dout_first on bits 1 and 9; without HOLD_EN -> exactly one dout_valid=0 gap between the two words.
REQ-031 Reset asserted at bit 5 of 8'hA5, then 8'h0C sent -> no residual A5 bits; output 0,0,0,0,1,1,0,0 with dout_first on the first bit.
REQ-032 din_valid held 1 while din_ready=0 with changing din -> only the words present on the accept cycles are emitted, in order.
